// File: rtl/game_round_ctrl.sv
// game_round_ctrl: two-player card game round sequencer with answer timer, scoring and winner decision
module game_round_ctrl #(
  parameter int          TIMEOUT_CYCLES = 50_000_000,
  parameter int          SHOW_CYCLES    = 25_000_000,
  parameter int          ROUNDS         = 8,
  parameter int          WIN_SCORE      = 5,
  parameter logic [3:0]  START_CODE     = 4'd12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_scan,
  input  logic       right,
  output logic       deal_en,
  output logic       whose,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] round_cnt,
  output logic       result_valid,
  output logic       result_ok,
  output logic       timeout_o,
  output logic [1:0] winner,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAL  = 3'd1,
    WAIT  = 3'd2,
    JUDGE = 3'd3,
    SHOW  = 3'd4,
    NEXT  = 3'd5,
    OVER  = 3'd6
  } state_t;
  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  score1_q, score1_d, score2_q, score2_d, round_q, round_d;
  logic [1:0]  winner_q, winner_d;
  logic        whose_q, whose_d, ok_q, ok_d, armed_q, armed_d;
  logic        press, start_press;
  // armed_q means the previous sample was idle; cleared in reset so a key held through release is ignored
  assign press       = armed_q && (key_scan != 4'd0);
  assign start_press = press && (key_scan == START_CODE);
  assign armed_d     = (key_scan == 4'd0);
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + 32'd1;
    score1_d     = score1_q;
    score2_d     = score2_q;
    round_d      = round_q;
    winner_d     = winner_q;
    whose_d      = whose_q;
    ok_d         = ok_q;
    deal_en      = 1'b0;
    result_valid = 1'b0;
    timeout_o    = 1'b0;
    result_ok    = ok_q;
    case (state_q)
      IDLE, OVER: if (start_press) begin
        score1_d = 4'd0;
        score2_d = 4'd0;
        round_d  = 4'd0;
        winner_d = 2'b00;
        ok_d     = 1'b0;
        whose_d  = 1'b0;
        state_d  = DEAL;
      end
      DEAL: begin
        deal_en = 1'b1;
        timer_d = 32'd0;
        state_d = WAIT;
      end
      WAIT: if (press && !start_press) state_d = JUDGE;
      else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
        timeout_o    = 1'b1;
        result_valid = 1'b1;
        result_ok    = 1'b0;
        ok_d         = 1'b0;
        timer_d      = 32'd0;
        state_d      = SHOW;
      end
      JUDGE: begin
        result_valid = 1'b1;
        result_ok    = right;
        ok_d         = right;
        score1_d     = (right && !whose_q && score1_q != 4'd15) ? score1_q + 4'd1 : score1_q;
        score2_d     = (right && whose_q && score2_q != 4'd15) ? score2_q + 4'd1 : score2_q;
        timer_d      = 32'd0;
        state_d      = SHOW;
      end
      SHOW: state_d = (timer_q == 32'(SHOW_CYCLES - 1)) ? NEXT : SHOW;
      NEXT: begin
        round_d = round_q + 4'd1;
        if (score1_q >= 4'(WIN_SCORE) || score2_q >= 4'(WIN_SCORE) || round_d == 4'(ROUNDS)) begin
          winner_d = (score1_q > score2_q) ? 2'b01 : (score2_q > score1_q) ? 2'b10 : 2'b11;
          state_d  = OVER;
        end else begin
          whose_d = ~whose_q;
          state_d = DEAL;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      timer_q  <= 32'd0;
      score1_q <= 4'd0;
      score2_q <= 4'd0;
      round_q  <= 4'd0;
      winner_q <= 2'b00;
      whose_q  <= 1'b0;
      ok_q     <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      round_q  <= round_d;
      winner_q <= winner_d;
      whose_q  <= whose_d;
      ok_q     <= ok_d;
      armed_q  <= armed_d;
    end
  end
  assign whose     = whose_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign round_cnt = round_q;
  assign winner    = winner_q;
  assign state_o   = state_q;
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed scenario tests for the game round sequencer
module tb_game_round_ctrl;
  logic       clk = 1'b0, rst = 1'b0, right = 1'b0;
  logic [3:0] key_scan = 4'd0;
  logic       deal_en, whose, result_valid, result_ok, timeout_o;
  logic [3:0] score1, score2, round_cnt;
  logic [1:0] winner;
  logic [2:0] state_o;
  int checks = 0, errors = 0;
  // ROUNDS=6 so that the P1 win at turn 5 is decided by the score limit rather than the round limit
  game_round_ctrl #(
    .TIMEOUT_CYCLES(20), .SHOW_CYCLES(4), .ROUNDS(6), .WIN_SCORE(3), .START_CODE(4'd12)
  ) dut (
    .clk(clk), .rst(rst), .key_scan(key_scan), .right(right), .deal_en(deal_en),
    .whose(whose), .score1(score1), .score2(score2), .round_cnt(round_cnt),
    .result_valid(result_valid), .result_ok(result_ok), .timeout_o(timeout_o),
    .winner(winner), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [3:0] c);
    key_scan = c;
    tick();
    key_scan = 4'd0;
  endtask
  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int n = 0;
    while (state_o !== s && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (state_o !== s) begin
      errors++;
      $display("FAIL %s: state_o=%0d expected %0d", nm, state_o, s);
    end
  endtask
  task automatic do_reset;
    rst = 1'b0;
    key_scan = 4'd0;
    right = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask
  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({deal_en, whose, score1, score2, round_cnt, result_valid, result_ok, timeout_o, winner, state_o} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero", {deal_en, whose, score1, score2, round_cnt, result_valid, result_ok, timeout_o, winner, state_o});
    end
    rst = 1'b1;
    tick();
  endtask
  task automatic test_start;
    press(4'd12);
    checks++;
    if (state_o !== 3'd1 || deal_en !== 1'b1 || whose !== 1'b0) begin
      errors++;
      $display("FAIL start_deal: state=%0d deal_en=%b whose=%b expected 1 1 0", state_o, deal_en, whose);
    end
    tick();
    checks++;
    if (state_o !== 3'd2 || deal_en !== 1'b0) begin
      errors++;
      $display("FAIL start_wait: state=%0d deal_en=%b expected 2 0", state_o, deal_en);
    end
  endtask
  task automatic test_answer;
    right = 1'b1;
    press(4'd5);
    checks++;
    if (state_o !== 3'd3 || result_valid !== 1'b1 || result_ok !== 1'b1 || score1 !== 4'd0) begin
      errors++;
      $display("FAIL answer_judge: state=%0d valid=%b ok=%b score1=%0d expected 3 1 1 0", state_o, result_valid, result_ok, score1);
    end
    tick();
    right = 1'b0;
    checks++;
    if (state_o !== 3'd4 || score1 !== 4'd1 || result_valid !== 1'b0 || result_ok !== 1'b1) begin
      errors++;
      $display("FAIL answer_show: state=%0d score1=%0d valid=%b ok=%b expected 4 1 0 1", state_o, score1, result_valid, result_ok);
    end
    repeat (3) tick();
    checks++;
    if (state_o !== 3'd4) begin
      errors++;
      $display("FAIL show_hold: state=%0d expected 4", state_o);
    end
    tick();
    checks++;
    if (state_o !== 3'd5) begin
      errors++;
      $display("FAIL show_to_next: state=%0d expected 5", state_o);
    end
    tick();
    checks++;
    if (state_o !== 3'd1 || deal_en !== 1'b1 || whose !== 1'b1 || round_cnt !== 4'd1) begin
      errors++;
      $display("FAIL next_deal: state=%0d deal=%b whose=%b round=%0d expected 1 1 1 1", state_o, deal_en, whose, round_cnt);
    end
    tick();
    right = 1'b1;
    press(4'd7);
    tick();
    right = 1'b0;
    checks++;
    if (score2 !== 4'd1 || score1 !== 4'd1) begin
      errors++;
      $display("FAIL p2_score: score1=%0d score2=%0d expected 1 1", score1, score2);
    end
  endtask
  task automatic test_timeout;
    do_reset();
    press(4'd12);
    tick();
    right = 1'b1;
    press(4'd5);
    tick();
    right = 1'b0;
    wait_state(3'd1, 50, "timeout_setup_deal");
    tick();
    checks++;
    if (state_o !== 3'd2 || result_ok !== 1'b1) begin
      errors++;
      $display("FAIL ok_held: state=%0d ok=%b expected 2 1", state_o, result_ok);
    end
    repeat (18) tick();
    checks++;
    if (timeout_o !== 1'b0 || state_o !== 3'd2) begin
      errors++;
      $display("FAIL timeout_early: timeout=%b state=%0d expected 0 2", timeout_o, state_o);
    end
    tick();
    checks++;
    if (timeout_o !== 1'b1 || result_valid !== 1'b1 || result_ok !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: timeout=%b valid=%b ok=%b expected 1 1 0", timeout_o, result_valid, result_ok);
    end
    repeat (6) tick();
    checks++;
    if (state_o !== 3'd1 || round_cnt !== 4'd2 || score1 !== 4'd1 || score2 !== 4'd0 || whose !== 1'b0) begin
      errors++;
      $display("FAIL timeout_to_deal: state=%0d round=%0d s1=%0d s2=%0d whose=%b expected 1 2 1 0 0", state_o, round_cnt, score1, score2, whose);
    end
  endtask
  task automatic test_expiry_press;
    tick();
    repeat (19) tick();
    key_scan = 4'd5;
    right = 1'b1;
    #1;
    checks++;
    if (timeout_o !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL expiry_press_pri: timeout=%b valid=%b expected 0 0", timeout_o, result_valid);
    end
    tick();
    key_scan = 4'd0;
    checks++;
    if (state_o !== 3'd3) begin
      errors++;
      $display("FAIL expiry_press_judge: state=%0d expected 3", state_o);
    end
    tick();
    right = 1'b0;
    checks++;
    if (score1 !== 4'd2) begin
      errors++;
      $display("FAIL expiry_press_score: score1=%0d expected 2", score1);
    end
  endtask
  task automatic test_held_key;
    int cnt = 0;
    do_reset();
    press(4'd12);
    tick();
    key_scan = 4'd3;
    repeat (10) begin
      tick();
      cnt += int'(result_valid);
    end
    checks++;
    if (cnt != 1 || state_o !== 3'd2 || round_cnt !== 4'd1 || score1 !== 4'd0) begin
      errors++;
      $display("FAIL held_key: judges=%0d state=%0d round=%0d score1=%0d expected 1 2 1 0", cnt, state_o, round_cnt, score1);
    end
    key_scan = 4'd0;
    tick();
    press(4'd12);
    tick();
    checks++;
    if (state_o !== 3'd2 || deal_en !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_in_wait: state=%0d deal=%b valid=%b expected 2 0 0", state_o, deal_en, result_valid);
    end
  endtask
  task automatic test_p1_wins;
    do_reset();
    press(4'd12);
    for (int t = 1; t <= 5; t++) begin
      wait_state(3'd2, 50, "turn_wait");
      right = (t % 2 == 1);
      press(4'd5);
      tick();
      right = 1'b0;
    end
    wait_state(3'd6, 50, "p1_over");
    repeat (3) tick();
    checks++;
    if (winner !== 2'b01 || score1 !== 4'd3 || score2 !== 4'd0 || round_cnt !== 4'd5 || state_o !== 3'd6) begin
      errors++;
      $display("FAIL p1_winner: winner=%b s1=%0d s2=%0d round=%0d state=%0d expected 01 3 0 5 6", winner, score1, score2, round_cnt, state_o);
    end
    press(4'd12);
    checks++;
    if (state_o !== 3'd1 || winner !== 2'b00 || score1 !== 4'd0 || round_cnt !== 4'd0 || whose !== 1'b0) begin
      errors++;
      $display("FAIL restart_from_over: state=%0d winner=%b s1=%0d round=%0d whose=%b expected 1 00 0 0 0", state_o, winner, score1, round_cnt, whose);
    end
  endtask
  task automatic test_timeouts_tie;
    do_reset();
    press(4'd12);
    wait_state(3'd6, 400, "tie_over");
    checks++;
    if (winner !== 2'b11 || round_cnt !== 4'd6 || score1 !== 4'd0 || score2 !== 4'd0) begin
      errors++;
      $display("FAIL tie_winner: winner=%b round=%0d s1=%0d s2=%0d expected 11 6 0 0", winner, round_cnt, score1, score2);
    end
  endtask
  task automatic test_reset_in_show;
    do_reset();
    press(4'd12);
    tick();
    right = 1'b1;
    press(4'd5);
    tick();
    right = 1'b0;
    checks++;
    if (state_o !== 3'd4 || score1 !== 4'd1) begin
      errors++;
      $display("FAIL pre_reset_show: state=%0d score1=%0d expected 4 1", state_o, score1);
    end
    rst = 1'b0;
    key_scan = 4'd12;
    tick();
    checks++;
    if ({deal_en, whose, score1, score2, round_cnt, result_valid, result_ok, timeout_o, winner, state_o} !== 22'd0) begin
      errors++;
      $display("FAIL reset_in_show: got %b expected all zero", {deal_en, whose, score1, score2, round_cnt, result_valid, result_ok, timeout_o, winner, state_o});
    end
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL held_through_reset: state=%0d expected 0", state_o);
    end
    key_scan = 4'd0;
    tick();
    press(4'd12);
    checks++;
    if (state_o !== 3'd1 || deal_en !== 1'b1) begin
      errors++;
      $display("FAIL start_after_reset: state=%0d deal=%b expected 1 1", state_o, deal_en);
    end
  endtask
  initial begin
    test_reset();
    test_start();
    test_answer();
    test_timeout();
    test_expiry_press();
    test_held_key();
    test_p1_wins();
    test_timeouts_tie();
    test_reset_in_show();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
